// File: rtl/axis_header_packetizer.sv
// Transmit packetizer: emits a 6-word header followed by payload read from a bank of BRAMs,
// as an AXI-Stream master with TLAST on the final beat of each packet.
module axis_header_packetizer #(
    parameter int          DATA_WIDTH = 16,
    parameter int          ADDR_WIDTH = 9,
    parameter int          BRAM_COUNT = 8,
    parameter logic [15:0] MAGIC      = 16'hC0DE
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             start,
    input  logic                             notification_only,
    input  logic [7:0]                       instruction_code,
    input  logic [2:0]                       rd_bram_start,
    input  logic [2:0]                       rd_bram_end,
    input  logic [15:0]                      rd_addr_start,
    input  logic [15:0]                      rd_addr_count,
    output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
    input  logic [BRAM_COUNT*DATA_WIDTH-1:0] bram_rd_data_flat,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             busy,
    output logic                             done,
    output logic                             err_bad_range,
    output logic [1:0]                       state_dbg
);

    // Stream handshake: a beat moves when tvalid & tready; once tvalid is raised,
    // tvalid, tdata and tlast hold until that beat has been accepted.
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE_P} state_t;

    state_t                  state;
    logic [2:0]              hdr_idx;
    logic                    hdr_only;
    logic [7:0]              ic_r;
    logic [2:0]              bs_r, be_r;
    logic [15:0]             as_r, ac_r;
    logic [19:0]             ld_left, rd_left;
    logic [2:0]              rd_bank, bank_d;
    logic [15:0]             rd_off;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    fifo_wp, fifo_rp;
    logic [1:0]              fifo_cnt;

    logic                    bad_range, accept, req_hdr_only;
    logic [3:0]              nbanks;
    logic [19:0]             total;
    logic                    load_ok, pop, issue;
    logic [2:0]              occupancy;
    logic [DATA_WIDTH-1:0]   lane, fifo_head;
    logic [15:0]             w1, w2, checksum, hdr_next;

    assign bad_range    = rd_bram_end < rd_bram_start;
    assign accept       = (state == IDLE) && start && !bad_range;
    assign req_hdr_only = notification_only || (rd_addr_count == 16'd0);
    assign nbanks       = 4'({1'b0, rd_bram_end} - {1'b0, rd_bram_start}) + 4'd1;
    assign total        = 20'(nbanks) * 20'(rd_addr_count);

    assign w1       = {8'h00, ic_r};
    assign w2       = {5'b0, be_r, 5'b0, bs_r};
    assign checksum = MAGIC ^ w1 ^ w2 ^ as_r ^ ac_r;

    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_next = w1;
            3'd1:    hdr_next = w2;
            3'd2:    hdr_next = as_r;
            3'd3:    hdr_next = ac_r;
            default: hdr_next = checksum;
        endcase
    end

    // Payload words come out of the FIFO; the header-to-data transition pops on the w5 handshake.
    assign load_ok   = !m_axis_tvalid || m_axis_tready;
    assign pop       = ((state == DATA) || ((state == HDR) && (hdr_idx == 3'd5))) &&
                       load_ok && (fifo_cnt != 2'd0) && (ld_left != 20'd0);
    // The slot freed by this cycle's pop is counted so reads keep pace at one word per clock.
    assign occupancy = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = ((state == HDR) || (state == DATA)) && (rd_left != 20'd0) &&
                       (occupancy < 3'd2);

    assign bram_rd_addr = ADDR_WIDTH'(as_r + rd_off);
    assign lane         = bram_rd_data_flat[int'(bank_d)*DATA_WIDTH +: DATA_WIDTH];
    assign fifo_head    = fifo_mem[fifo_rp];
    assign state_dbg    = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            hdr_idx       <= '0;
            hdr_only      <= 1'b0;
            ic_r          <= '0;
            bs_r          <= '0;
            be_r          <= '0;
            as_r          <= '0;
            ac_r          <= '0;
            ld_left       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_bad_range <= 1'b0;
        end else begin
            done          <= 1'b0;
            err_bad_range <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && bad_range) begin
                        err_bad_range <= 1'b1;
                    end else if (start) begin
                        state         <= HDR;
                        hdr_idx       <= '0;
                        hdr_only      <= req_hdr_only;
                        ic_r          <= instruction_code;
                        bs_r          <= rd_bram_start;
                        be_r          <= rd_bram_end;
                        as_r          <= rd_addr_start;
                        ac_r          <= rd_addr_count;
                        ld_left       <= req_hdr_only ? 20'd0 : total;
                        m_axis_tdata  <= DATA_WIDTH'(MAGIC);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                HDR: begin
                    if (m_axis_tready) begin
                        if (hdr_idx != 3'd5) begin
                            m_axis_tdata <= DATA_WIDTH'(hdr_next);
                            m_axis_tlast <= hdr_only && (hdr_idx == 3'd4);
                            hdr_idx      <= hdr_idx + 3'd1;
                        end else if (hdr_only) begin
                            state         <= DONE_P;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            state <= DATA;
                            if (pop) begin
                                m_axis_tdata  <= fifo_head;
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (ld_left == 20'd1);
                                ld_left       <= ld_left - 20'd1;
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (load_ok) begin
                        if (m_axis_tvalid && m_axis_tlast) begin
                            state         <= DONE_P;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else if (pop) begin
                            m_axis_tdata  <= fifo_head;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (ld_left == 20'd1);
                            ld_left       <= ld_left - 20'd1;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end
                    end
                end
                DONE_P:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read side: issue a read, carry its bank index one cycle, capture the returned lane.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_left  <= '0;
            rd_bank  <= '0;
            rd_off   <= '0;
            inflight <= 1'b0;
            bank_d   <= '0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            inflight <= issue;
            bank_d   <= rd_bank;
            if (accept) begin
                rd_left <= req_hdr_only ? 20'd0 : total;
                rd_bank <= rd_bram_start;
                rd_off  <= '0;
            end else if (issue) begin
                rd_left <= rd_left - 20'd1;
                if (rd_off == ac_r - 16'd1) begin
                    rd_off  <= '0;
                    rd_bank <= rd_bank + 3'd1;
                end else begin
                    rd_off <= rd_off + 16'd1;
                end
            end
            if (inflight) fifo_wp <= ~fifo_wp;
            if (pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge aclk) begin
        if (inflight) fifo_mem[fifo_wp] <= lane;
    end

endmodule

// File: tb/tb_axis_header_packetizer.sv
// Bench for axis_header_packetizer: BRAM bank model, stream monitor, and a
// packet-level reference model that builds the expected beat list per request.
module tb_axis_header_packetizer;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         start = 1'b0;
    logic         notification_only = 1'b0;
    logic [7:0]   instruction_code = '0;
    logic [2:0]   rd_bram_start = '0;
    logic [2:0]   rd_bram_end = '0;
    logic [15:0]  rd_addr_start = '0;
    logic [15:0]  rd_addr_count = '0;
    logic [8:0]   bram_rd_addr;
    logic [127:0] bram_rd_data_flat = '0;
    logic [15:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         busy;
    logic         done;
    logic         err_bad_range;
    logic [1:0]   state_dbg;

    axis_header_packetizer dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .notification_only(notification_only),
        .instruction_code(instruction_code), .rd_bram_start(rd_bram_start),
        .rd_bram_end(rd_bram_end), .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data_flat(bram_rd_data_flat),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .err_bad_range(err_bad_range),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // BRAM bank model, 1-cycle read latency
    logic [15:0] mem [8][512];
    initial begin
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 512; a++) mem[b][a] = 16'($urandom);
    end
    always @(posedge aclk) begin
        for (int b = 0; b < 8; b++) bram_rd_data_flat[b*16 +: 16] <= mem[b][bram_rd_addr];
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          stable_err = 0;
    int          err_cnt = 0;
    int          first_cyc = 0, last_cyc = 0, done_cyc = 0;
    logic        busy_at_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat = '0;

    // monitor, sampled mid-cycle
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall && !(m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} == prev_beat)))
                stable_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (got_q.size() == 0) first_cyc = cyc;
                got_q.push_back({m_axis_tlast, m_axis_tdata});
                if (m_axis_tlast) last_cyc = cyc;
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (err_bad_range) err_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // tready generator: 0 = always ready, 1 = random 50%, 2 = random plus 3-cycle stalls
    int rmode = 0;
    int s2 = 0, s6 = 0;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (rmode == 0) begin
                m_axis_tready = 1'b1;
            end else if (rmode == 1) begin
                m_axis_tready = 1'($urandom_range(0, 1));
            end else if (got_q.size() == 2 && s2 < 3) begin
                m_axis_tready = 1'b0;
                s2++;
            end else if (got_q.size() == 6 && s6 < 3) begin
                m_axis_tready = 1'b0;
                s6++;
            end else begin
                m_axis_tready = 1'($urandom_range(0, 1));
            end
        end
    end

    // reference model: header words then payload in bank/address order
    task automatic build_expected(input logic [7:0] ic, input logic [2:0] bs, input logic [2:0] be,
                                  input logic [15:0] as, input logic [15:0] ac, input logic notif);
        logic [15:0] h [6];
        logic [16:0] tail;
        exp_q.delete();
        h[0] = 16'hC0DE;
        h[1] = {8'h00, ic};
        h[2] = {5'b0, be, 5'b0, bs};
        h[3] = as;
        h[4] = ac;
        h[5] = h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[4];
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, h[i]});
        if (!notif && ac != 0) begin
            for (int b = int'(bs); b <= int'(be); b++)
                for (int o = 0; o < int'(ac); o++)
                    exp_q.push_back({1'b0, mem[b][(int'(as) + o) % 512]});
        end
        tail = exp_q.pop_back();
        exp_q.push_back(tail | 17'h10000);
    endtask

    // driver tasks
    task automatic send_start(input logic [7:0] ic, input logic [2:0] bs, input logic [2:0] be,
                              input logic [15:0] as, input logic [15:0] ac, input logic notif);
        @(posedge aclk);
        #1;
        got_q.delete();
        instruction_code  = ic;
        rd_bram_start     = bs;
        rd_bram_end       = be;
        rd_addr_start     = as;
        rd_addr_count     = ac;
        notification_only = notif;
        start             = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge aclk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done, err_bad_range} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {m_axis_tvalid, m_axis_tlast, busy, done, err_bad_range});
        end
        n_checks++;
        if ({m_axis_tdata, bram_rd_addr} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_data: got tdata %h addr %h expected 0", m_axis_tdata, bram_rd_addr);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
    endtask

    task automatic test_single();
        bit to;
        rmode = 0;
        build_expected(8'h05, 3'd0, 3'd0, 16'd0, 16'd4, 1'b0);
        send_start(8'h05, 3'd0, 3'd0, 16'd0, 16'd4, 1'b0);
        @(negedge aclk);
        n_checks++;
        if ({m_axis_tvalid, busy, m_axis_tdata} !== {2'b11, 16'hC0DE}) begin
            n_fail++;
            $display("FAIL single_latency: got v%b b%b %h expected v1 b1 c0de",
                     m_axis_tvalid, busy, m_axis_tdata);
        end
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout: got no done expected done"); end
        n_checks++;
        if (got_q.size() != 10) begin
            n_fail++;
            $display("FAIL single_len: got %0d expected 10", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (got_q.size() > 5 && got_q[5] !== 17'h0C0DF) begin
            n_fail++;
            $display("FAIL single_checksum: got %h expected 0c0df", got_q[5]);
        end
        n_checks++;
        if (done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done@%0d busy %b expected done@%0d busy 0",
                     done_cyc, busy_at_done, last_cyc + 1);
        end
    endtask

    task automatic test_wrap();
        bit to;
        rmode = 0;
        build_expected(8'hA7, 3'd2, 3'd4, 16'd510, 16'd3, 1'b0);
        send_start(8'hA7, 3'd2, 3'd4, 16'd510, 16'd3, 1'b0);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL wrap_timeout: got no done expected done"); end
        n_checks++;
        if (got_q.size() != 15) begin
            n_fail++;
            $display("FAIL wrap_len: got %0d expected 15", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (last_cyc - first_cyc + 1 != 15) begin
            n_fail++;
            $display("FAIL wrap_throughput: got %0d cycles expected 15", last_cyc - first_cyc + 1);
        end
    endtask

    task automatic test_notify();
        bit to;
        rmode = 0;
        build_expected(8'h3C, 3'd1, 3'd6, 16'd40, 16'd100, 1'b1);
        send_start(8'h3C, 3'd1, 3'd6, 16'd40, 16'd100, 1'b1);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL notify_timeout: got no done expected done"); end
        n_checks++;
        if (got_q.size() != 6) begin
            n_fail++;
            $display("FAIL notify_len: got %0d expected 6", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL notify_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        s2 = 0;
        s6 = 0;
        stable_err = 0;
        rmode = 2;
        build_expected(8'hA7, 3'd2, 3'd4, 16'd510, 16'd3, 1'b0);
        send_start(8'hA7, 3'd2, 3'd4, 16'd510, 16'd3, 1'b0);
        wait_done(to);
        rmode = 0;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL stall_timeout: got no done expected done"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (stable_err != 0 || s2 != 3 || s6 != 3) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d unstable, stalls %0d/%0d expected 0, 3/3",
                     stable_err, s2, s6);
        end
    endtask

    task automatic test_bad_range();
        bit to;
        int errs_before;
        rmode = 0;
        send_start(8'h11, 3'd5, 3'd3, 16'd0, 16'd4, 1'b0);
        @(negedge aclk);
        n_checks++;
        if ({err_bad_range, busy, m_axis_tvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL bad_range_pulse: got err%b busy%b v%b expected 1 0 0",
                     err_bad_range, busy, m_axis_tvalid);
        end
        @(negedge aclk);
        n_checks++;
        if ({err_bad_range, busy, m_axis_tvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL bad_range_after: got err%b busy%b v%b expected 0 0 0",
                     err_bad_range, busy, m_axis_tvalid);
        end
        errs_before = err_cnt;
        build_expected(8'h22, 3'd1, 3'd1, 16'd7, 16'd5, 1'b0);
        send_start(8'h22, 3'd1, 3'd1, 16'd7, 16'd5, 1'b0);
        @(posedge aclk);
        #1;
        rd_bram_start = 3'd6;
        rd_bram_end   = 3'd2;
        start         = 1'b1;
        @(posedge aclk);
        #1;
        rd_bram_start = 3'd0;
        rd_bram_end   = 3'd7;
        @(posedge aclk);
        #1;
        start = 1'b0;
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL busy_start_timeout: got no done expected done"); end
        repeat (12) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (got_q.size() != exp_q.size() || m_axis_tvalid !== 1'b0 || busy !== 1'b0 ||
            err_cnt != errs_before) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %0d beats v%b busy%b errs %0d expected %0d 0 0 %0d",
                     got_q.size(), m_axis_tvalid, busy, err_cnt, exp_q.size(), errs_before);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy_start_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit reached;
        rmode = 0;
        send_start(8'h44, 3'd0, 3'd7, 16'($urandom), 16'd20, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (got_q.size() >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL rst_mid_progress: got %0d beats expected >=10", got_q.size());
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({m_axis_tvalid, busy, m_axis_tlast} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got v%b busy%b last%b expected 0 0 0",
                     m_axis_tvalid, busy, m_axis_tlast);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        rmode = 1;
        build_expected(8'h55, 3'd3, 3'd5, 16'd100, 16'd7, 1'b0);
        send_start(8'h55, 3'd3, 3'd5, 16'd100, 16'd7, 1'b0);
        wait_done(to);
        rmode = 0;
        n_checks++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rst_mid_len: got %0d beats (timeout %b) expected %0d",
                     got_q.size(), to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [16:0] g;
            g = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_mid_beat %0d: got %h expected %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int p = 0; p < 8; p++) begin
            logic [7:0]  ic;
            logic [2:0]  bs, be;
            logic [15:0] as, ac;
            logic        nt;
            ic    = 8'($urandom);
            bs    = 3'($urandom_range(0, 7));
            be    = 3'($urandom_range(int'(bs), 7));
            as    = 16'($urandom);
            ac    = 16'($urandom_range(0, 10));
            nt    = ($urandom_range(0, 3) == 0);
            rmode = (p % 2 == 0) ? 1 : 0;
            build_expected(ic, bs, be, as, ac, nt);
            send_start(ic, bs, be, as, ac, nt);
            wait_done(to);
            n_checks++;
            if (to || got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand_len pkt %0d: got %0d beats (timeout %b) expected %0d",
                         p, got_q.size(), to, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                logic [16:0] g;
                g = (i < got_q.size()) ? got_q[i] : 17'bx;
                n_checks++;
                if (g !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_beat pkt %0d beat %0d: got %h expected %h", p, i, g, exp_q[i]);
                end
            end
        end
        rmode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_notify();
        test_stall();
        test_bad_range();
        test_reset_mid();
        test_random();
        repeat (5) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
